// File: rtl/data_sync_hs_if.sv
// Handshake bundle between a source-domain word/toggle producer, the consumer and data_sync_hs.
// Latency: none, this file only groups wires.
// Backpressure: none here; the consumer paces reads with DST_RD, and the source is paced by ACK_TGL or by rate limiting.
//
// Signals:
//   UNSYNC_BUS   source word, held stable from a REQ_TGL change until it is acked or consumed
//   REQ_TGL      source request toggle, one change per new word
//   DST_RD       consumer read strobe
//   SYNC_BUS     captured word
//   VALID        SYNC_BUS holds an unread word
//   ENABLE_PULSE one-cycle pulse on each capture
//   OVERRUN      sticky flag for a dropped word
//   ACK_TGL      toggle returned to the source for each consumed word
// Modports:
//   master  source plus consumer side
//   slave   the synchronizer
interface data_sync_hs_if #(
    parameter int BUS_WIDTH = 8
);
    logic [BUS_WIDTH-1:0] UNSYNC_BUS;
    logic                 REQ_TGL;
    logic                 DST_RD;
    logic [BUS_WIDTH-1:0] SYNC_BUS;
    logic                 VALID;
    logic                 ENABLE_PULSE;
    logic                 OVERRUN;
    logic                 ACK_TGL;

    modport master (
        output UNSYNC_BUS, REQ_TGL, DST_RD,
        input  SYNC_BUS, VALID, ENABLE_PULSE, OVERRUN, ACK_TGL
    );

    modport slave (
        input  UNSYNC_BUS, REQ_TGL, DST_RD,
        output SYNC_BUS, VALID, ENABLE_PULSE, OVERRUN, ACK_TGL
    );
endinterface

// File: rtl/data_sync_hs.sv
// Destination-side toggle-handshake bus synchronizer: it captures a source word on each REQ_TGL change and holds it until it is read.
// Latency: a REQ_TGL change first sampled at posedge k updates SYNC_BUS, VALID and ENABLE_PULSE at posedge k+NUM_STAGES.
// Backpressure: there is none toward the source. A word that arrives while the held word is unread is dropped and sets OVERRUN.
//
// Ports:
//   CLK  destination clock; all logic runs on posedge
//   RST  synchronous active-high reset, with priority over every other input
//   bus  data_sync_hs_if.slave bundle: UNSYNC_BUS, REQ_TGL and DST_RD in; SYNC_BUS, VALID,
//        ENABLE_PULSE, OVERRUN and ACK_TGL out
// Optional feature:
//   `define DATA_SYNC_HS_ACK_EN builds the ACK_TGL flop. Without it, ACK_TGL is tied to 0.
module data_sync_hs #(
    parameter int NUM_STAGES = 2,
    parameter int BUS_WIDTH  = 8
) (
    input  logic           CLK,
    input  logic           RST,
    data_sync_hs_if.slave  bus
);
    // Request synchronizer chain plus the edge-detect flop.
    logic [NUM_STAGES-1:0] r_req_s;
    logic                  r_req_d;
    logic                  w_edge;

    // VALID is the whole FSM state: 0 = EMPTY, 1 = FULL.
    logic                  r_valid;
    logic                  w_valid_nxt;

    logic [BUS_WIDTH-1:0]  r_sync_bus;
    logic                  r_enable_pulse;
    logic                  r_overrun;

    logic                  w_accept;
    logic                  w_capture;
    logic                  w_drop;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_req_s <= '0;
            r_req_d <= 1'b0;
        end else begin
            r_req_s <= {r_req_s[NUM_STAGES-2:0], bus.REQ_TGL};
            r_req_d <= r_req_s[NUM_STAGES-1];
        end
    end

    assign w_edge = r_req_s[NUM_STAGES-1] ^ r_req_d;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_valid_nxt;
        end
    end

    // Next-state logic. A read and a new edge in the same cycle keep the FSM FULL.
    always_comb begin
        w_valid_nxt = r_valid;
        if (!r_valid) begin
            if (w_edge) begin
                w_valid_nxt = 1'b1;
            end
        end else if (bus.DST_RD && !w_edge) begin
            w_valid_nxt = 1'b0;
        end
    end

    // Action decode. In FULL, an edge is captured only if the held word is read in the same cycle.
    always_comb begin
        w_accept  = r_valid & bus.DST_RD;
        w_capture = w_edge & (~r_valid | bus.DST_RD);
        w_drop    = w_edge & r_valid & ~bus.DST_RD;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync_bus     <= '0;
            r_enable_pulse <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_enable_pulse <= w_capture;
            if (w_capture) begin
                r_sync_bus <= bus.UNSYNC_BUS;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

`ifdef DATA_SYNC_HS_ACK_EN
    // One inversion per consumed word, including a read that coincides with a capture.
    logic r_ack_tgl;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ack_tgl <= 1'b0;
        end else if (w_accept) begin
            r_ack_tgl <= ~r_ack_tgl;
        end
    end

    assign bus.ACK_TGL = r_ack_tgl;
`else
    logic w_unused_accept;
    assign w_unused_accept = w_accept;
    assign bus.ACK_TGL     = 1'b0;
`endif

    assign bus.SYNC_BUS     = r_sync_bus;
    assign bus.VALID        = r_valid;
    assign bus.ENABLE_PULSE = r_enable_pulse;
    assign bus.OVERRUN      = r_overrun;
endmodule

// File: tb/tb_data_sync_hs.sv
// Testbench for data_sync_hs: directed scenarios followed by randomized compliant-source traffic.
// Latency: expected outputs come from a queue-based reference model and are compared each cycle.
// Backpressure: the consumer read strobe is driven randomly in the random phase.
module tb_data_sync_hs;
    localparam int NS = 2;
    localparam int W  = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    data_sync_hs_if #(.BUS_WIDTH(W)) bus_if ();

    data_sync_hs #(.NUM_STAGES(NS), .BUS_WIDTH(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_if)
    );

    // Reference model. m_hist holds the REQ_TGL value seen at each posedge. The word is
    // detected NS posedges after it first appears, as the XOR of two successive samples.
    bit         m_hist[$];
    bit         m_valid;
    bit [W-1:0] m_data;
    bit         m_pulse;
    bit         m_ovr;
    bit         m_ack;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle's inputs, advance the model, cross one posedge, then compare at negedge.
    task automatic step(input logic rst, input logic req, input logic [W-1:0] d, input logic rd);
        bit e;
        bit acc;
        RST               = rst;
        bus_if.REQ_TGL    = req;
        bus_if.UNSYNC_BUS = d;
        bus_if.DST_RD     = rd;
        if (rst) begin
            m_hist.delete();
            repeat (NS + 1) m_hist.push_back(1'b0);
            m_valid = 0;
            m_data  = '0;
            m_pulse = 0;
            m_ovr   = 0;
            m_ack   = 0;
        end else begin
            m_hist.push_back(req);
            e   = m_hist[m_hist.size()-1-NS] ^ m_hist[m_hist.size()-2-NS];
            acc = m_valid && rd;
`ifdef DATA_SYNC_HS_ACK_EN
            if (acc) m_ack = ~m_ack;
`endif
            m_pulse = 0;
            if (e && (!m_valid || rd)) begin
                m_data  = d;
                m_valid = 1;
                m_pulse = 1;
            end else if (e) begin
                m_ovr = 1;
            end else if (acc) begin
                m_valid = 0;
            end
            if (m_hist.size() > 64) void'(m_hist.pop_front());
        end
        @(posedge CLK);
        @(negedge CLK);
        check("sync_bus", bus_if.SYNC_BUS, m_data);
        check("valid", bus_if.VALID, m_valid);
        check("enable_pulse", bus_if.ENABLE_PULSE, m_pulse);
        check("overrun", bus_if.OVERRUN, m_ovr);
        check("ack_tgl", bus_if.ACK_TGL, m_ack);
    endtask

    logic       req;
    logic [W-1:0] d;
    int         cnt;

    initial begin
        bus_if.REQ_TGL    = 1'b0;
        bus_if.UNSYNC_BUS = '0;
        bus_if.DST_RD     = 1'b0;
        req = 1'b0;
        @(negedge CLK);

        // Reset with an idle source, then 10 idle cycles.
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        check("rst_valid", bus_if.VALID, 0);
        check("rst_sync_bus", bus_if.SYNC_BUS, 0);
        repeat (10) step(0, 0, 8'h00, 0);
        check("idle_valid", bus_if.VALID, 0);
        check("idle_pulse", bus_if.ENABLE_PULSE, 0);

        // Single word, with capture on the third posedge after the toggle.
        step(0, 1, 8'hA5, 0);
        step(0, 1, 8'hA5, 0);
        check("single_before", bus_if.VALID, 0);
        step(0, 1, 8'hA5, 0);
        check("single_data", bus_if.SYNC_BUS, 8'hA5);
        check("single_pulse", bus_if.ENABLE_PULSE, 1);
        step(0, 1, 8'hA5, 0);
        check("single_pulse_end", bus_if.ENABLE_PULSE, 0);
        step(0, 1, 8'hA5, 1);
        check("single_read_valid", bus_if.VALID, 0);
        check("single_read_data", bus_if.SYNC_BUS, 8'hA5);

        // Overrun: 0x11 stays unread and 0x22 is dropped.
        repeat (4) step(0, 0, 8'h11, 0);
        repeat (4) step(0, 1, 8'h22, 0);
        check("ovr_data", bus_if.SYNC_BUS, 8'h11);
        check("ovr_flag", bus_if.OVERRUN, 1);
        repeat (3) step(0, 1, 8'h22, 1);
        check("ovr_sticky", bus_if.OVERRUN, 1);

        // Simultaneous read and capture, starting from a clean reset.
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        repeat (4) step(0, 1, 8'h33, 0);
        check("simul_hold", bus_if.SYNC_BUS, 8'h33);
        step(0, 0, 8'h44, 0);
        step(0, 0, 8'h44, 0);
        step(0, 0, 8'h44, 1);
        check("simul_data", bus_if.SYNC_BUS, 8'h44);
        check("simul_valid", bus_if.VALID, 1);
        check("simul_pulse", bus_if.ENABLE_PULSE, 1);
        check("simul_ovr", bus_if.OVERRUN, 0);
        step(0, 0, 8'h44, 1);

        // Reset one cycle after a toggle. The source also returns REQ_TGL to 0.
        step(0, 1, 8'h55, 0);
        step(1, 0, 8'h55, 0);
        repeat (5) step(0, 0, 8'h55, 0);
        check("midrst_valid", bus_if.VALID, 0);
        check("midrst_data", bus_if.SYNC_BUS, 0);

        // Four words, each read back.
        req = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            req = ~req;
            repeat (NS + 2) step(0, req, W'(i), 0);
            step(0, req, W'(i), 1);
            step(0, req, W'(i), 0);
        end
        check("ack_final", bus_if.ACK_TGL, 0);
        check("four_last_data", bus_if.SYNC_BUS, 8'h04);

        // Randomized compliant source, consumer and occasional reset.
        req = 1'b0;
        d   = '0;
        cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199) == 0) begin
                req = 1'b0;
                cnt = 0;
                step(1, req, d, $urandom_range(1));
            end else begin
                if (cnt >= NS + 2 && $urandom_range(2) == 0) begin
                    req = ~req;
                    d   = W'($urandom);
                    cnt = 0;
                end else begin
                    cnt++;
                end
                step(0, req, d, ($urandom_range(2) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
